mem_access_unit: RTL and testbench

- Sits between the datapath load/store path and the word-addressed data memory (256 x 32, registered read, synchronous write).
- Converts byte-addressed LW/LH/LHU/LB/LBU/SW/SH/SB requests into word accesses.
- Extracts and sign/zero-extends load data.
- Performs read-modify-write for sub-word stores.
- Stalls the core through busy until the access completes.

---
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word-addressed 256x32 data memory.
// Formats load data, performs read-modify-write for sub-word stores, and stalls via busy.
module mem_access_unit #(
  parameter int unsigned LITTLE_ENDIAN   = 1,
  parameter int unsigned ERR_ON_MISALIGN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic [31:0] mem_adress,
  output logic [31:0] mem_in_data,
  output logic        mem_memWr,
  output logic        mem_memRd,
  input  logic [31:0] mem_out_data
);

  localparam logic [2:0] OpLw  = 3'b000;
  localparam logic [2:0] OpLh  = 3'b001;
  localparam logic [2:0] OpLhu = 3'b010;
  localparam logic [2:0] OpLb  = 3'b011;
  localparam logic [2:0] OpLbu = 3'b100;
  localparam logic [2:0] OpSw  = 3'b101;
  localparam logic [2:0] OpSh  = 3'b110;
  localparam logic [2:0] OpSb  = 3'b111;

  typedef enum logic [2:0] {StIdle, StRead, StFmt, StMerge, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_in_data_q, mem_in_data_d;
  logic        err_q, err_d;

  logic        misaligned;
  logic [31:0] addr_aligned;
  logic [1:0]  byte_sel;
  logic        half_sel;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] fmt_word;
  logic [31:0] merged_word;

  // Alignment check on the incoming request; byte ops are always aligned.
  always_comb begin
    misaligned   = 1'b0;
    addr_aligned = addr;
    case (op)
      OpLw, OpSw: begin
        misaligned   = |addr[1:0];
        addr_aligned = {addr[31:2], 2'b00};
      end
      OpLh, OpLhu, OpSh: begin
        misaligned   = addr[0];
        addr_aligned = {addr[31:1], 1'b0};
      end
      default: ;
    endcase
  end

  // Big-endian mirrors the lane index within the word.
  assign byte_sel = (LITTLE_ENDIAN != 0) ? addr_q[1:0] : ~addr_q[1:0];
  assign half_sel = (LITTLE_ENDIAN != 0) ? addr_q[1]   : ~addr_q[1];
  assign lane_b   = mem_out_data[{byte_sel, 3'b000} +: 8];
  assign lane_h   = mem_out_data[{half_sel, 4'b0000} +: 16];

  always_comb begin
    case (op_q)
      OpLh:    fmt_word = {{16{lane_h[15]}}, lane_h};
      OpLhu:   fmt_word = {16'h0000, lane_h};
      OpLb:    fmt_word = {{24{lane_b[7]}}, lane_b};
      OpLbu:   fmt_word = {24'h000000, lane_b};
      default: fmt_word = mem_out_data;
    endcase
  end

  always_comb begin
    merged_word = mem_out_data;
    if (op_q == OpSb) begin
      merged_word[{byte_sel, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged_word[{half_sel, 4'b0000} +: 16] = wdata_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    mem_in_data_d = mem_in_data_q;
    err_d         = err_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          op_d    = op;
          wdata_d = wdata[15:0];
          addr_d  = (ERR_ON_MISALIGN != 0) ? addr : addr_aligned;
          err_d   = 1'b0;
          if (misaligned && (ERR_ON_MISALIGN != 0)) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (op == OpSw) begin
            mem_in_data_d = wdata;
            state_d       = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead:  state_d = (op_q <= OpLbu) ? StFmt : StMerge;
      StFmt: begin
        rdata_d = fmt_word;
        state_d = StDone;
      end
      StMerge: begin
        mem_in_data_d = merged_word;
        state_d       = StWrite;
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      op_q          <= 3'b000;
      addr_q        <= 32'h0;
      wdata_q       <= 16'h0;
      rdata_q       <= 32'h0;
      mem_in_data_q <= 32'h0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      mem_in_data_q <= mem_in_data_d;
      err_q         <= err_d;
    end
  end

  assign rdata       = rdata_q;
  assign err         = err_q;
  assign mem_in_data = mem_in_data_q;
  assign mem_adress  = {2'b00, addr_q[31:2]};
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign mem_memRd   = (state_q == StRead);
  assign mem_memWr   = (state_q == StWrite);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random traffic checked against a
// byte-array reference model of the memory and the load/store rules.
module tb_mem_access_unit;

  localparam logic [2:0] OpLw  = 3'b000;
  localparam logic [2:0] OpLh  = 3'b001;
  localparam logic [2:0] OpLhu = 3'b010;
  localparam logic [2:0] OpLb  = 3'b011;
  localparam logic [2:0] OpLbu = 3'b100;
  localparam logic [2:0] OpSw  = 3'b101;
  localparam logic [2:0] OpSh  = 3'b110;
  localparam logic [2:0] OpSb  = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        err;
  logic [31:0] mem_adress;
  logic [31:0] mem_in_data;
  logic        mem_memWr;
  logic        mem_memRd;
  logic [31:0] mem_out_data;

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .op           (op),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .done         (done),
    .busy         (busy),
    .err          (err),
    .mem_adress   (mem_adress),
    .mem_in_data  (mem_in_data),
    .mem_memWr    (mem_memWr),
    .mem_memRd    (mem_memRd),
    .mem_out_data (mem_out_data)
  );

  always #5 clk = ~clk;

  // Data memory: 256 x 32, registered read, synchronous write.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_memWr) mem[mem_adress[7:0]] <= mem_in_data;
    if (mem_memRd) mem_out_data <= mem[mem_adress[7:0]];
  end

  // Free-running strobe monitor, sampled mid-cycle.
  int          rd_tot = 0;
  int          wr_tot = 0;
  int          both_tot = 0;
  logic [31:0] last_adr = 32'h0;
  always @(negedge clk) begin
    if (mem_memRd) rd_tot++;
    if (mem_memWr) wr_tot++;
    if (mem_memRd && mem_memWr) both_tot++;
    if (mem_memRd || mem_memWr) last_adr = mem_adress;
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: plain byte-addressed memory, little-endian.
  logic [7:0]  rb [1024];
  logic [31:0] ref_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [9:0] a);
    logic [9:0] b;
    b = {a[9:2], 2'b00};
    return {rb[b + 10'd3], rb[b + 10'd2], rb[b + 10'd1], rb[b]};
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] o, input logic [31:0] a);
    if (o == OpLw || o == OpSw) return (a % 4) != 0;
    if (o == OpLh || o == OpLhu || o == OpSh) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] a);
    logic [9:0]  i;
    logic [15:0] h;
    logic [7:0]  b;
    i = a[9:0];
    b = rb[i];
    h = {rb[i + 10'd1], rb[i]};
    case (o)
      OpLh:    return (h >= 16'h8000) ? 32'hFFFF0000 + 32'(h) : 32'(h);
      OpLhu:   return 32'(h);
      OpLb:    return (b >= 8'h80) ? 32'hFFFFFF00 + 32'(b) : 32'(b);
      OpLbu:   return 32'(b);
      default: return ref_word(i);
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd);
    logic [9:0] i;
    i = a[9:0];
    rb[i] = wd[7:0];
    if (o == OpSh || o == OpSw) rb[i + 10'd1] = wd[15:8];
    if (o == OpSw) begin
      rb[i + 10'd2] = wd[23:16];
      rb[i + 10'd3] = wd[31:24];
    end
  endtask

  // One request; returns one cycle after done, with the DUT back in idle.
  task automatic do_access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd);
    logic mis;
    logic is_load;
    int   exp_lat, erd, ewr, cyc, rd0, wr0, both0;
    mis     = ref_misaligned(o, a);
    is_load = (o <= OpLbu);
    if (mis)          begin exp_lat = 1; erd = 0; ewr = 0; end
    else if (is_load) begin exp_lat = 3; erd = 1; ewr = 0; end
    else if (o == OpSw) begin exp_lat = 2; erd = 0; ewr = 1; end
    else              begin exp_lat = 4; erd = 1; ewr = 1; end
    rd0 = rd_tot; wr0 = wr_tot; both0 = both_tot;
    req = 1'b1; op = o; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    cyc = 1;
    chk("busy_after_req", 32'(busy), 32'd1);
    while (!done && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, exp_lat);
    chk("err", 32'(err), 32'(mis));
    if (!mis) begin
      if (is_load) ref_rdata = ref_load(o, a);
      else ref_store(o, a, wd);
    end
    chk("rdata", rdata, ref_rdata);
    chk("rd_strobes", rd_tot - rd0, erd);
    chk("wr_strobes", wr_tot - wr0, ewr);
    chk("rd_wr_overlap", both_tot - both0, 0);
    if (erd + ewr > 0) chk("mem_adress", last_adr, {2'b00, a[31:2]});
    if (!is_load) chk("mem_word", mem[a[9:2]], ref_word(a[9:0]));
    @(posedge clk); #1;
  endtask

  initial begin
    int          cyc, rd0;
    logic [2:0]  o;
    logic [31:0] a;
    rst_n = 1'b0; req = 1'b0; op = 3'b000; addr = 32'h0; wdata = 32'h0;
    ref_rdata = 32'h0;
    #2;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_strobes", {30'd0, mem_memRd, mem_memWr}, 32'd0);
    chk("rst_mem_in_data", mem_in_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) do_access(OpSw, 32'(i * 4), $urandom);

    // Reset during the WRITE cycle of a SW: strobe drops at once, memory untouched.
    req = 1'b1; op = OpSw; addr = 32'h10; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req = 1'b0;
    chk("sw_in_write", 32'(mem_memWr), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_memWr", 32'(mem_memWr), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_mid_mem_in_data", mem_in_data, 32'h0);
    chk("rst_mid_mem_adress", mem_adress, 32'h0);
    ref_rdata = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_idle_busy", 32'(busy), 32'd0);
    chk("rst_word4_kept", mem[4], ref_word(10'h10));

    do_access(OpSw, 32'h20, 32'hDEADBEEF);
    do_access(OpLw, 32'h20, 32'h0);
    chk("lw_deadbeef", rdata, 32'hDEADBEEF);

    do_access(OpSw, 32'h20, 32'h11223344);
    do_access(OpSb, 32'h21, 32'h000000A5);
    do_access(OpLw, 32'h20, 32'h0);
    chk("sb_merge", rdata, 32'h1122A544);

    do_access(OpSw, 32'h30, 32'h80FF7F01);
    do_access(OpLb, 32'h30, 32'h0);
    chk("lb_30", rdata, 32'h00000001);
    do_access(OpLb, 32'h32, 32'h0);
    chk("lb_32", rdata, 32'hFFFFFFFF);
    do_access(OpLbu, 32'h33, 32'h0);
    chk("lbu_33", rdata, 32'h00000080);
    do_access(OpLh, 32'h32, 32'h0);
    chk("lh_32", rdata, 32'hFFFF80FF);
    do_access(OpLhu, 32'h32, 32'h0);
    chk("lhu_32", rdata, 32'h000080FF);

    do_access(OpLw, 32'h22, 32'h0);
    do_access(OpSh, 32'h23, 32'h0000BEEF);
    chk("misalign_rdata_kept", rdata, 32'h000080FF);
    do_access(OpLw, 32'h30, 32'h0);
    chk("err_cleared", 32'(err), 32'd0);

    // req held high through an LB: one access, then a second accepted after the idle cycle.
    rd0 = rd_tot;
    req = 1'b1; op = OpLb; addr = 32'h31; wdata = 32'h0;
    @(posedge clk); #1;
    cyc = 1;
    while (!done && cyc < 10) begin
      chk("held_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      cyc++;
    end
    chk("held_latency1", cyc, 3);
    @(posedge clk); #1;
    chk("held_idle_gap", 32'(busy), 32'd0);
    @(posedge clk); #1;
    req = 1'b0;
    chk("held_second_start", 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("held_latency2", cyc, 3);
    chk("held_reads", rd_tot - rd0, 2);
    ref_rdata = ref_load(OpLb, 32'h31);
    chk("held_rdata", rdata, ref_rdata);
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      do_access(o, a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
